// File: rtl/sample_averager.sv
// Decimating boxcar averager for the packed two-channel ADC stream.
// Averages 2**LOG2_AVG samples per channel, or forwards samples unchanged in bypass.
module sample_averager #(
    parameter int ZMOD_DATA_SIZE = 14,
    parameter int AXIS_DATA_SIZE = 32,
    parameter int LOG2_AVG       = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [AXIS_DATA_SIZE-1:0] i_data,
    input  logic                      i_data_valid,
    output logic [AXIS_DATA_SIZE-1:0] o_data,
    output logic                      o_data_valid,
    output logic [15:0]               o_block_count
);

    localparam int ACC_W = ZMOD_DATA_SIZE + LOG2_AVG;
    localparam logic [LOG2_AVG-1:0] CNT_LAST = '1;
    localparam logic [LOG2_AVG-1:0] CNT_ONE  = LOG2_AVG'(1);

    // Valid/ready contract: no backpressure; i_data is taken on any cycle i_data_valid
    // is high, and o_data is valid only in the single cycle o_data_valid is high.
    typedef enum logic {
        ST_BYPASS = 1'b0,
        ST_ACCUM  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic signed [ACC_W-1:0]   r_acc1;
    logic signed [ACC_W-1:0]   r_acc2;
    logic [LOG2_AVG-1:0]       r_cnt;

    logic                      w_mode_change;
    logic signed [ACC_W-1:0]   w_acc1_base;
    logic signed [ACC_W-1:0]   w_acc2_base;
    logic [LOG2_AVG-1:0]       w_cnt_base;
    logic signed [ACC_W-1:0]   w_ch1_ext;
    logic signed [ACC_W-1:0]   w_ch2_ext;
    logic signed [ACC_W-1:0]   w_sum1;
    logic signed [ACC_W-1:0]   w_sum2;
    logic                      w_block_done;
    logic                      w_emit;
    logic [AXIS_DATA_SIZE-1:0] w_field_mask;
    logic [AXIS_DATA_SIZE-1:0] w_out_word;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= w_next_state;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The mode follows i_enable directly, so a sample on the switching cycle
    // is already handled by the new mode while the old partial sum is dropped.
    always_comb begin
        w_next_state  = i_enable ? ST_ACCUM : ST_BYPASS;
        w_mode_change = (w_next_state != r_state);
        w_acc1_base   = w_mode_change ? '0 : r_acc1;
        w_acc2_base   = w_mode_change ? '0 : r_acc2;
        w_cnt_base    = w_mode_change ? '0 : r_cnt;

        w_ch1_ext = {{LOG2_AVG{i_data[ZMOD_DATA_SIZE+15]}}, i_data[ZMOD_DATA_SIZE+15:16]};
        w_ch2_ext = {{LOG2_AVG{i_data[ZMOD_DATA_SIZE-1]}}, i_data[ZMOD_DATA_SIZE-1:0]};
        w_sum1    = w_acc1_base + w_ch1_ext;
        w_sum2    = w_acc2_base + w_ch2_ext;

        w_block_done = i_data_valid && (w_next_state == ST_ACCUM) && (w_cnt_base == CNT_LAST);
        w_emit       = i_data_valid && ((w_next_state == ST_BYPASS) || w_block_done);

        w_field_mask = '0;
        w_field_mask[ZMOD_DATA_SIZE+15:16]  = '1;
        w_field_mask[ZMOD_DATA_SIZE-1:0]    = '1;

        w_out_word = '0;
        if (w_next_state == ST_BYPASS) begin
            w_out_word = i_data & w_field_mask;
        end else begin
            // Taking the upper ZMOD bits is the floor-rounding arithmetic shift, truncated.
            w_out_word[ZMOD_DATA_SIZE+15:16] = w_sum1[ACC_W-1:LOG2_AVG];
            w_out_word[ZMOD_DATA_SIZE-1:0]   = w_sum2[ACC_W-1:LOG2_AVG];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc1        <= '0;
            r_acc2        <= '0;
            r_cnt         <= '0;
            o_data        <= '0;
            o_data_valid  <= 1'b0;
            o_block_count <= '0;
        end else begin
            o_data_valid <= w_emit;
            if (w_emit) begin
                o_data        <= w_out_word;
                o_block_count <= o_block_count + 16'd1;
            end

            if ((w_next_state == ST_BYPASS) || w_block_done) begin
                r_acc1 <= '0;
                r_acc2 <= '0;
                r_cnt  <= '0;
            end else if (i_data_valid) begin
                r_acc1 <= w_sum1;
                r_acc2 <= w_sum2;
                r_cnt  <= w_cnt_base + CNT_ONE;
            end else if (w_mode_change) begin
                r_acc1 <= '0;
                r_acc2 <= '0;
                r_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sample_averager.sv
// Bench for sample_averager: directed vectors, a queue-based averaging model checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_sample_averager;

    localparam int N_AVG = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic [15:0] o_block_count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // model state
    int          q1[$];
    int          q2[$];
    logic [31:0] m_data;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic        m_prev_en;

    sample_averager #(
        .ZMOD_DATA_SIZE(14),
        .AXIS_DATA_SIZE(32),
        .LOG2_AVG(2)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_block_count(o_block_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input int c1, input int c2);
        logic [31:0] w;
        w = '0;
        w[29:16] = c1[13:0];
        w[13:0]  = c2[13:0];
        return w;
    endfunction

    function automatic int floor_avg(input int vals[$]);
        int s;
        s = 0;
        foreach (vals[k]) s += vals[k];
        if (s >= 0) return s / vals.size();
        return -((-s + vals.size() - 1) / vals.size());
    endfunction

    // Behavioural model: collect samples per channel, emit the floor mean of each full block.
    always @(posedge clk) begin
        m_valid = 1'b0;
        if (i_reset) begin
            q1.delete();
            q2.delete();
            m_data    = '0;
            m_cnt     = '0;
            m_prev_en = i_enable;
        end else begin
            if (i_enable != m_prev_en) begin
                q1.delete();
                q2.delete();
            end
            m_prev_en = i_enable;
            if (i_data_valid) begin
                if (!i_enable) begin
                    m_data  = i_data & 32'h3FFF_3FFF;
                    m_valid = 1'b1;
                    m_cnt   = m_cnt + 16'd1;
                end else begin
                    q1.push_back(int'($signed(i_data[29:16])));
                    q2.push_back(int'($signed(i_data[13:0])));
                    if (q1.size() == N_AVG) begin
                        m_data  = pack(floor_avg(q1), floor_avg(q2));
                        m_valid = 1'b1;
                        m_cnt   = m_cnt + 16'd1;
                        q1.delete();
                        q2.delete();
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_valid", {31'd0, o_data_valid}, {31'd0, m_valid});
            check("model_data", o_data, m_data);
            check("model_count", {16'd0, o_block_count}, {16'd0, m_cnt});
        end
    end

    task automatic drive(input logic en, input logic v, input logic [31:0] d);
        @(negedge clk);
        i_reset      = 1'b0;
        i_enable     = en;
        i_data_valid = v;
        i_data       = d;
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        i_reset      = 1'b1;
        i_enable     = en;
        i_data_valid = 1'b0;
        i_data       = '0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] d, input logic [15:0] c);
        check({name, "_valid"}, {31'd0, o_data_valid}, 32'd1);
        check({name, "_data"}, o_data, d);
        check({name, "_count"}, {16'd0, o_block_count}, {16'd0, c});
    endtask

    initial begin
        i_reset      = 1'b1;
        i_enable     = 1'b1;
        i_data_valid = 1'b0;
        i_data       = '0;
        repeat (2) @(negedge clk);
        started = 1'b1;
        check("reset_data", o_data, 32'h0);
        check("reset_valid", {31'd0, o_data_valid}, 32'd0);
        check("reset_count", {16'd0, o_block_count}, 32'd0);

        // basic average of 100..400
        drive(1, 1, pack(100, 0));
        drive(1, 1, pack(200, 0));
        drive(1, 1, pack(300, 0));
        drive(1, 1, pack(400, 0));
        drive(1, 0, 0);
        expect_out("avg_250", 32'h00FA_0000, 16'd1);

        // full-scale extremes
        for (int k = 0; k < 4; k++) drive(1, 1, pack(-8192, 8191));
        drive(1, 0, 0);
        expect_out("extremes", 32'h2000_1FFF, 16'd2);

        // floor rounding both signs
        drive(1, 1, pack(-1, 0));
        drive(1, 1, pack(-1, 0));
        drive(1, 1, pack(-1, 0));
        drive(1, 1, pack(0, 0));
        drive(1, 0, 0);
        expect_out("floor_neg", 32'h3FFF_0000, 16'd3);
        drive(1, 1, pack(1, 0));
        drive(1, 1, pack(1, 0));
        drive(1, 1, pack(1, 0));
        drive(1, 1, pack(0, 0));
        drive(1, 0, 0);
        expect_out("floor_pos", 32'h0000_0000, 16'd4);

        // bypass echo with masking; first sample lands on the switching cycle
        drive(0, 1, 32'h1ABC_0123);
        drive(0, 0, 0);
        expect_out("bypass_a", 32'h1ABC_0123, 16'd5);
        drive(0, 1, 32'hC000_3FFF);
        drive(0, 0, 0);
        expect_out("bypass_b", 32'h0000_3FFF, 16'd6);
        drive(0, 0, 0);
        check("bypass_no_repeat", {31'd0, o_data_valid}, 32'd0);

        // reset mid-block drops the partial sum
        for (int k = 0; k < 3; k++) drive(1, 1, pack(5, 5));
        do_reset(1);
        for (int k = 0; k < 4; k++) drive(1, 1, pack(10, 10));
        drive(1, 0, 0);
        expect_out("after_reset", 32'h000A_000A, 16'd1);

        // enable toggle mid-block drops the partial sum
        for (int k = 0; k < 3; k++) drive(1, 1, pack(5, 5));
        drive(0, 0, 0);
        for (int k = 0; k < 4; k++) drive(1, 1, pack(10, 10));
        drive(1, 0, 0);
        expect_out("after_toggle", 32'h000A_000A, 16'd2);

        // random back-to-back accumulation, checked by the model
        for (int k = 0; k < 24; k++) drive(1, 1, $urandom);
        drive(1, 0, 0);

        // counter wrap with continuous strobes
        do_reset(0);
        for (int k = 0; k < 65535; k++) drive(0, 1, $urandom);
        drive(0, 0, 0);
        expect_out("count_ffff", o_data, 16'hFFFF);
        drive(0, 1, 32'h0001_0002);
        drive(0, 0, 0);
        expect_out("count_wrap", 32'h0001_0002, 16'h0000);
        drive(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
